// File: rtl/f9pcap_tx_arbiter.sv
// ---------------------------------------------------------------------------
// f9pcap_tx_arbiter
//
// Shares one TEMAC transmit port between SRC_COUNT AXI-Stream frame sources.
// A round-robin arbiter grants whole frames. Once a source is granted it owns
// the tx port until its last beat is accepted. After the frame, an optional
// programmable idle gap is inserted before the next grant.
//
// Ports
//   clk_in         single clock, all logic in this domain
//   rst_n_in       synchronous active-low reset
//   link_ready_in  TEMAC link up; gates new grants only
//   sgap_cfg_in    idle cycles inserted after each frame (sampled on last beat)
//   src_valid_in   per-source AXIS valid
//   src_ready_out  per-source AXIS ready (only the granted source sees ready)
//   src_data_in    per-source data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_last_in    per-source end-of-frame
//   tx_valid_out   TEMAC tx valid
//   tx_ready_in    TEMAC tx ready
//   tx_data_out    TEMAC tx data
//   tx_last_out    TEMAC tx last
//   grant_out      one-hot current grant, zero when no grant is held
//   busy_out       high while transferring a frame or timing the gap
//   frame_cnt_out  completed frames sent, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module f9pcap_tx_arbiter #(
  parameter int unsigned SRC_COUNT  = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SGAP_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            link_ready_in,
  input  logic [SGAP_WIDTH-1:0]           sgap_cfg_in,
  input  logic [SRC_COUNT-1:0]            src_valid_in,
  output logic [SRC_COUNT-1:0]            src_ready_out,
  input  logic [SRC_COUNT*DATA_WIDTH-1:0] src_data_in,
  input  logic [SRC_COUNT-1:0]            src_last_in,
  output logic                            tx_valid_out,
  input  logic                            tx_ready_in,
  output logic [DATA_WIDTH-1:0]           tx_data_out,
  output logic                            tx_last_out,
  output logic [SRC_COUNT-1:0]            grant_out,
  output logic                            busy_out,
  output logic [CNT_WIDTH-1:0]            frame_cnt_out
);

  localparam int unsigned IDX_W = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e                state_q;
  logic [SRC_COUNT-1:0]  grant_q;
  logic [IDX_W-1:0]      gidx_q;
  logic [IDX_W-1:0]      last_q;
  logic [SGAP_WIDTH-1:0] gap_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  busy_q;

  // Arbiter result for the current IDLE cycle
  logic                  found_d;
  logic [IDX_W-1:0]      gidx_d;
  logic [SRC_COUNT-1:0]  grant_d;

  // Granted source's signals
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  in_xfer;
  logic                  last_hs;

  // Round-robin search: offsets 1..SRC_COUNT from the last granted index,
  // so the last winner is tried last and the lowest index after it wins.
  always_comb begin
    int unsigned cand;
    logic [IDX_W-1:0] cand_idx;
    found_d  = 1'b0;
    gidx_d   = '0;
    grant_d  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= SRC_COUNT; k++) begin
      cand     = (32'(last_q) + k) % SRC_COUNT;
      cand_idx = IDX_W'(cand);
      if (!found_d && src_valid_in[cand_idx]) begin
        found_d = 1'b1;
        gidx_d  = cand_idx;
      end
    end
    grant_d[gidx_d] = found_d;
  end

  // Granted-source mux. grant_q is only non-zero in XFER, so the copies
  // collapse to zero everywhere else.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < SRC_COUNT; i++) begin
      if (grant_q[i]) begin
        sel_valid = src_valid_in[i];
        sel_last  = src_last_in[i];
        sel_data  = src_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign in_xfer = (state_q == XFER);
  assign last_hs = in_xfer && sel_valid && tx_ready_in && sel_last;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(SRC_COUNT - 1);
      gap_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (link_ready_in && found_d) begin
            state_q <= XFER;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            busy_q  <= 1'b1;
          end
        end
        XFER: begin
          if (last_hs) begin
            cnt_q   <= cnt_q + CNT_WIDTH'(1);
            last_q  <= gidx_q;
            grant_q <= '0;
            if (sgap_cfg_in == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= GAP;
              gap_q   <= sgap_cfg_in;
            end
          end
        end
        GAP: begin
          // Leaving on a count of 1 gives exactly N cycles spent in GAP.
          if (gap_q == SGAP_WIDTH'(1)) begin
            state_q <= IDLE;
            gap_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - SGAP_WIDTH'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign src_ready_out = in_xfer ? (grant_q & {SRC_COUNT{tx_ready_in}}) : '0;
  assign tx_valid_out  = in_xfer && sel_valid;
  assign tx_last_out   = in_xfer && sel_last;
  assign tx_data_out   = in_xfer ? sel_data : '0;
  assign grant_out     = grant_q;
  assign busy_out      = busy_q;
  assign frame_cnt_out = cnt_q;

endmodule
